// File: rtl/io_cmd_controller_pkg.sv
// Shared definitions for the IO command controller: opcode bit positions,
// clear-engine state encoding and the default fill character.
package io_ctrl_pkg;

   // Position of the opcode byte inside the 16-bit command word
   localparam int OPCODE_LSB   = 8;

   // Bit indices inside the opcode byte
   localparam int OP_SEL       = 0;  // 0: font / clear screen, 1: background / clear line
   localparam int OP_SET_COLOR = 1;
   localparam int OP_CLEAR     = 2;
   localparam int OP_SET_LINE  = 3;

   // Clear engine states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_t;

   // Character written by the clear engine unless overridden
   localparam logic [7:0] DEF_CLEAR_CHAR = 8'h20;

endpackage

// File: rtl/io_cmd_controller_if.sv
// Command port between the CPU IO side (master) and the controller (slave):
// 16-bit command words moved with a valid/ready handshake.
interface io_cmd_controller_if;

   logic        io_valid;
   logic        io_ready;
   logic [15:0] io_data;

   modport master (
      output io_valid,
      output io_data,
      input  io_ready
   );

   modport slave (
      input  io_valid,
      input  io_data,
      output io_ready
   );

endinterface

// File: rtl/io_cmd_controller_clear_sequencer.sv
// Clear engine: walks an address window [base_addr, base_addr+length-1],
// issuing one write request per address and advancing only on accepted beats.
module clear_sequencer
   import io_ctrl_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              ready,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic              busy,
   output logic              done
);

   clr_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] end_q, end_d;

   // Last address of the window; one extra bit so a full power-of-two
   // length cannot overflow before the subtraction.
   logic [ADDR_W:0] end_wide;
   logic            end_wide_unused;

   assign end_wide        = ({1'b0, base_addr} + length) - (ADDR_W+1)'(1);
   assign end_wide_unused = end_wide[ADDR_W];

   // State, address counter and end-address registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         end_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         end_q   <= end_d;
      end
   end

   // Next-state and output decode; the address holds under a stall and is
   // left at the last accepted value once the window is finished.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      end_d   = end_q;
      we      = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
               addr_d  = base_addr;
               end_d   = end_wide[ADDR_W-1:0];
            end
         end
         CLEAR: begin
            we = 1'b1;
            if (ready) begin
               if (addr_q == end_q) begin
                  state_d = DONE;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign addr = addr_q;
   assign busy = (state_q != IDLE);

endmodule

// File: rtl/io_cmd_controller.sv
// IO command decoder for the text console: holds font/background colours and
// the cursor line, and launches screen or line clears on the text buffer.
module io_cmd_controller
   import io_ctrl_pkg::*;
#(
   parameter int                COLOR_W    = 8,
   parameter int                CHAR_W     = 8,
   parameter int                COLS       = 80,
   parameter int                ROWS       = 30,
   parameter logic [CHAR_W-1:0] CLEAR_CHAR = DEF_CLEAR_CHAR,
   localparam int               ADDR_W     = $clog2(COLS*ROWS),
   localparam int               LINE_W     = $clog2(ROWS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   io_cmd_controller_if.slave          io,
   output logic [2*COLOR_W-1:0]        color_data,
   output logic [LINE_W-1:0]           cur_line,
   output logic                        busy,
   output logic                        clr_done,
   output logic                        clr_we,
   input  logic                        clr_ready,
   output logic [ADDR_W-1:0]           clr_addr,
   output logic [CHAR_W+2*COLOR_W-1:0] clr_data
);

   logic [COLOR_W-1:0] font_q, font_d;
   logic [COLOR_W-1:0] bg_q, bg_d;
   logic [LINE_W-1:0]  line_q, line_d;

   logic               accept;
   logic               op_sel, op_color, op_clear, op_line;
   logic [7:0]         operand;
   logic               line_ok;
   logic               clear_start;
   logic [ADDR_W-1:0]  clear_base;
   logic [ADDR_W:0]    clear_len;
   logic               reserved_unused;

   // Opcode fields; the upper opcode nibble is reserved and ignored
   assign op_sel          = io.io_data[OPCODE_LSB+OP_SEL];
   assign op_color        = io.io_data[OPCODE_LSB+OP_SET_COLOR];
   assign op_clear        = io.io_data[OPCODE_LSB+OP_CLEAR];
   assign op_line         = io.io_data[OPCODE_LSB+OP_SET_LINE];
   assign operand         = io.io_data[7:0];
   assign reserved_unused = ^io.io_data[15:12];

   // Commands are only taken while the clear engine is idle, so a pending
   // command simply waits and colours cannot change under a running clear.
   assign io.io_ready = ~busy;
   assign accept      = io.io_valid & io.io_ready;
   assign line_ok     = int'(operand) < ROWS;

   // Colour and line registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         font_q <= '1;
         bg_q   <= '0;
         line_q <= '0;
      end else begin
         font_q <= font_d;
         bg_q   <= bg_d;
         line_q <= line_d;
      end
   end

   // Command decode: colour first, then line, then the clear is set up from
   // the already-updated line so a combined word clears the new line.
   always_comb begin
      font_d      = font_q;
      bg_d        = bg_q;
      line_d      = line_q;
      clear_start = 1'b0;
      clear_base  = '0;
      clear_len   = (ADDR_W+1)'(COLS*ROWS);
      if (accept) begin
         if (op_color) begin
            if (op_sel) bg_d   = io.io_data[COLOR_W-1:0];
            else        font_d = io.io_data[COLOR_W-1:0];
         end
         if (op_line && line_ok) begin
            line_d = operand[LINE_W-1:0];
         end
         clear_start = op_clear;
      end
      if (op_sel) begin
         clear_base = ADDR_W'(line_d) * ADDR_W'(COLS);
         clear_len  = (ADDR_W+1)'(COLS);
      end
   end

   clear_sequencer #(
      .ADDR_W (ADDR_W)
   ) u_clear_sequencer (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (clear_start),
      .ready     (clr_ready),
      .base_addr (clear_base),
      .length    (clear_len),
      .we        (clr_we),
      .addr      (clr_addr),
      .busy      (busy),
      .done      (clr_done)
   );

   assign color_data = {font_q, bg_q};
   assign cur_line   = line_q;
   assign clr_data   = {CLEAR_CHAR, font_q, bg_q};

endmodule

// File: tb/tb_io_cmd_controller.sv
// Scoreboard bench for io_cmd_controller: commands update a reference model that
// queues the expected fill writes; a monitor checks every accepted beat.
module tb_io_cmd_controller;

   localparam int COLS      = 80;
   localparam int ROWS      = 30;
   localparam int NCELL     = COLS*ROWS;
   localparam int CYC_LIMIT = 12000;

   typedef struct {
      bit          is_done;
      int          addr;
      logic [23:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr_ready = 1'b0;
   logic [15:0] color_data;
   logic [4:0]  cur_line;
   logic        busy, clr_done, clr_we;
   logic [11:0] clr_addr;
   logic [23:0] clr_data;

   int   tests = 0;
   int   fails = 0;
   int   beat_cnt = 0;
   int   ready_mode = 0;
   bit   done_seen = 1'b0;
   exp_t exp_q[$];

   // Reference model state
   logic [7:0] m_font = 8'hFF;
   logic [7:0] m_bg   = 8'h00;
   int         m_line = 0;

   io_cmd_controller_if bus();

   io_cmd_controller dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io         (bus),
      .color_data (color_data),
      .cur_line   (cur_line),
      .busy       (busy),
      .clr_done   (clr_done),
      .clr_we     (clr_we),
      .clr_ready  (clr_ready),
      .clr_addr   (clr_addr),
      .clr_data   (clr_data)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out (no response), expected a response", name);
   endtask

   // Reference behaviour of one accepted command word
   task automatic model_apply(input logic [15:0] w);
      logic [7:0] op;
      logic [7:0] opd;
      int         base, n;
      op  = w[15:8];
      opd = w[7:0];
      if (op[1]) begin
         if (op[0]) m_bg = opd;
         else       m_font = opd;
      end
      if (op[3] && int'(opd) < ROWS) m_line = int'(opd);
      if (op[2]) begin
         base = op[0] ? m_line*COLS : 0;
         n    = op[0] ? COLS : NCELL;
         for (int i = 0; i < n; i++) begin
            exp_q.push_back('{is_done: 1'b0, addr: base + i, data: {8'h20, m_font, m_bg}});
         end
         exp_q.push_back('{is_done: 1'b1, addr: 0, data: 24'h0});
      end
   endtask

   // Text-buffer side back-pressure
   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       clr_ready = 1'b1;
         1:       clr_ready = ~clr_ready;
         default: clr_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: compares every write beat and done pulse against the scoreboard
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (done_seen) begin
            check("ready_after_done", {30'd0, bus.io_ready, busy}, 32'h2);
            done_seen = 1'b0;
         end
         if (clr_we) begin
            check("ready_low_in_clear", {30'd0, bus.io_ready, busy}, 32'h1);
            if (exp_q.size() == 0 || exp_q[0].is_done) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got addr %0d, required no write", clr_addr);
            end else if (clr_ready) begin
               check("wr_addr", 32'(clr_addr), 32'(exp_q[0].addr));
               check("wr_data", 32'(clr_data), 32'(exp_q[0].data));
               void'(exp_q.pop_front());
               beat_cnt++;
            end else begin
               check("stall_addr", 32'(clr_addr), 32'(exp_q[0].addr));
            end
         end
         if (clr_done) begin
            if (exp_q.size() > 0 && exp_q[0].is_done) begin
               tests++;
               void'(exp_q.pop_front());
               $display("[TB] clear done at beat %0d", beat_cnt);
            end else begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got clr_done=1 with %0d beats pending, required 0", exp_q.size());
            end
            done_seen = 1'b1;
         end
      end
   end

   // Issue one command and wait (bounded) for it to be accepted
   task automatic send_cmd(input logic [15:0] w);
      int cyc;
      cyc = 0;
      @(posedge clk);
      #1;
      bus.io_valid = 1'b1;
      bus.io_data  = w;
      forever begin
         @(negedge clk);
         if (bus.io_ready) break;
         cyc++;
         if (cyc > CYC_LIMIT) begin
            fail_now("accept_timeout");
            bus.io_valid = 1'b0;
            return;
         end
      end
      check("queue_empty_at_accept", 32'(exp_q.size()), 32'd0);
      model_apply(w);
      @(posedge clk);
      #1;
      bus.io_valid = 1'b0;
      @(negedge clk);
      check("color_data", 32'(color_data), {16'd0, m_font, m_bg});
      check("cur_line", 32'(cur_line), 32'(m_line));
      $display("[TB] cmd %04h accepted: font=%02h bg=%02h line=%0d queued=%0d",
               w, m_font, m_bg, m_line, exp_q.size());
   endtask

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 || !bus.io_ready) begin
         @(negedge clk);
         cyc++;
         if (cyc > CYC_LIMIT) begin
            fail_now("idle_timeout");
            exp_q.delete();
            return;
         end
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_font    = 8'hFF;
      m_bg      = 8'h00;
      m_line    = 0;
      done_seen = 1'b0;
   endtask

   initial begin
      int start_beats;
      int cyc;
      logic [7:0] op;
      logic [7:0] opd;

      bus.io_valid = 1'b0;
      bus.io_data  = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1. reset state
      @(negedge clk);
      check("rst_color", 32'(color_data), 32'hFF00);
      check("rst_ready", 32'(bus.io_ready), 32'd1);
      check("rst_we", 32'(clr_we), 32'd0);
      check("rst_line", 32'(cur_line), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // 2. colour loads
      send_cmd(16'h0212);
      send_cmd(16'h0334);

      // 3. line clear of line 5
      ready_mode  = 0;
      send_cmd(16'h0805);
      start_beats = beat_cnt;
      send_cmd(16'h0500);
      wait_idle();
      check("line_clear_beats", 32'(beat_cnt - start_beats), 32'd80);

      // 3b. same line clear through the sel path
      start_beats = beat_cnt;
      send_cmd(16'h0501);
      wait_idle();
      check("line_clear_beats_sel", 32'(beat_cnt - start_beats), 32'd80);

      // 4. screen clear under alternating back-pressure, command held meanwhile
      ready_mode  = 1;
      start_beats = beat_cnt;
      send_cmd(16'h0400);
      send_cmd(16'h025A);
      wait_idle();
      check("screen_clear_beats", 32'(beat_cnt - start_beats), 32'(NCELL));

      // 5. out-of-range line with a line clear: old line (5) is cleared
      ready_mode = 2;
      send_cmd(16'h0DEE);
      wait_idle();

      // 6. reset in the middle of a screen clear
      ready_mode  = 0;
      start_beats = beat_cnt;
      send_cmd(16'h0400);
      cyc = 0;
      while (beat_cnt - start_beats < 1000 && cyc < CYC_LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= CYC_LIMIT) fail_now("mid_clear_wait");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_we", 32'(clr_we), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_color", 32'(color_data), 32'hFF00);
      check("midrst_ready", 32'(bus.io_ready), 32'd1);
      $display("[TB] reset asserted after %0d beats of screen clear", beat_cnt - start_beats);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_idle", {30'd0, busy, clr_we}, 32'd0);
      start_beats = beat_cnt;
      send_cmd(16'h0501);
      wait_idle();
      check("post_rst_clear_beats", 32'(beat_cnt - start_beats), 32'd80);

      // Randomised command stream
      for (int it = 0; it < 40; it++) begin
         ready_mode = int'($urandom_range(0, 2));
         op  = 8'($urandom_range(0, 255));
         opd = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) opd = 8'($urandom_range(0, ROWS-1));
         if (op[2] && !op[0] && (it % 10 != 3)) op[0] = 1'b1;
         send_cmd({op, opd});
         wait_idle();
      end

      repeat (5) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
